// File: rtl/mux_arb_rr.sv
// rtl/mux_arb_rr.sv - registered N-to-1 valid/ready mux with fixed-select and round-robin modes
module mux_arb_rr #(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [CH_W-1:0]         sel,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]         out_ch,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic              out_valid_q, out_valid_d;
  logic [CH_W-1:0]   last_q, last_d;

  logic              load;
  logic              found;
  logic              xfer;
  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   gnt_idx;
  logic [WIDTH-1:0]  gnt_data;

  // The output register may take a new word when empty or being drained this cycle.
  assign load = !out_valid_q || out_ready;

  // Grant selection: fixed channel in mode 0, round-robin after `last` in mode 1.
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    gnt_idx  = '0;
    gnt_data = '0;
    if (!mode) begin
      // An out-of-range sel matches no channel, so it yields no grant.
      for (int i = 0; i < NUM_CH; i++) begin
        if (sel == CH_W'(i) && in_valid[i]) begin
          grant[i] = 1'b1;
        end
      end
    end else begin
      // Search last+1, last+2, ... so the previous winner gets lowest priority.
      for (int k = 1; k <= NUM_CH; k++) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (!found && (i == (int'(last_q) + k) % NUM_CH) && in_valid[i]) begin
            grant[i] = 1'b1;
            found    = 1'b1;
          end
        end
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) begin
        gnt_idx  = CH_W'(i);
        gnt_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Accept only when the register can load; nothing is accepted while reset is held.
  assign in_ready = (rst_n && load) ? grant : '0;
  assign xfer     = |in_ready;

  // Next state: load on input transfer, otherwise clear valid when drained.
  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
    if (xfer) begin
      out_data_d  = gnt_data;
      out_ch_d    = gnt_idx;
      out_valid_d = 1'b1;
      last_d      = gnt_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset leaves channel 0 with top round-robin priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      last_q      <= CH_W'(NUM_CH - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_arb_rr.sv
// tb/tb_mux_arb_rr.sv - scoreboard bench for mux_arb_rr with randomized and directed traffic
module tb_mux_arb_rr;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int CW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           mode = 1'b0;
  logic [CW-1:0]  sel = '0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_valid = '0;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [CW-1:0]  out_ch;
  logic           out_valid;
  logic           out_ready = 1'b0;

  always #5 clk = ~clk;

  mux_arb_rr #(.WIDTH(W), .NUM_CH(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    logic [W-1:0] d;
    int           ch;
  } item_t;

  item_t        sbq[$];
  int           checks = 0;
  int           failures = 0;
  int           ready_mode = 1;   // 0 random, 1 always ready, 2 never ready
  logic [W-1:0] chd[N];
  bit           chk_rst = 1'b0;

  // Reference model of the output register and round-robin pointer.
  bit           m_valid = 1'b0;
  logic [W-1:0] m_data = '0;
  int           m_ch = 0;
  int           m_last = N - 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Winning channel by the selection rules, or -1 when nobody is granted.
  function automatic int pick(input bit md, input int s, input logic [N-1:0] v, input int last);
    logic [N-1:0] t;
    if (!md) begin
      if (s >= N) return -1;
      t = v >> s;
      return t[0] ? s : -1;
    end
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      t = v >> c;
      if (t[0]) return c;
    end
    return -1;
  endfunction

  // Consumer/monitor: drives out_ready and checks every word it takes.
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'($urandom_range(0, 1));
        1:       out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
      if (rst_n && out_valid === 1'b1 && out_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_underflow got=word exp=none");
        end else begin
          it = sbq.pop_front();
          chk("sb_out_data", out_data, it.d);
          chk("sb_out_ch", out_ch, it.ch);
        end
      end
    end
  end

  // One cycle of stimulus followed by the model update for the coming edge.
  task automatic step(input bit rn, input bit md, input int s, input logic [N-1:0] v, input int rm);
    int           g;
    bit           ld;
    logic [N-1:0] er;
    @(negedge clk);
    rst_n      = rn;
    mode       = md;
    sel        = CW'(s);
    in_valid   = v;
    ready_mode = rm;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = chd[i];
    #3;
    if (chk_rst) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_ch", out_ch, 0);
      chk_rst = 1'b0;
    end
    if (!rn) begin
      chk("in_ready_in_reset", in_ready, 0);
      sbq.delete();
      m_valid = 1'b0;
      m_data  = '0;
      m_ch    = 0;
      m_last  = N - 1;
    end else begin
      chk("out_valid", out_valid, m_valid);
      chk("out_data_hold", out_data, m_data);
      chk("out_ch_hold", out_ch, m_ch);
      ld = !m_valid || out_ready;
      g  = pick(md, s, v, m_last);
      er = (g >= 0 && ld) ? (4'b0001 << g) : 4'b0000;
      chk("in_ready", in_ready, er);
      if (er != 0) begin
        sbq.push_back('{d: chd[g], ch: g});
        m_last  = g;
        m_valid = 1'b1;
        m_data  = chd[g];
        m_ch    = g;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) chd[i] = 32'hA0 + i;

    // Reset with everything requesting, then stream A0..A3 round-robin.
    step(0, 1, 0, 4'hF, 1);
    step(0, 1, 0, 4'hF, 1);
    chk_rst = 1'b1;
    step(1, 1, 0, 4'hF, 1);
    repeat (7) step(1, 1, 0, 4'hF, 1);

    // Reset mid-stream: channel 0 must win first again.
    step(0, 1, 0, 4'hF, 1);
    chk_rst = 1'b1;
    step(1, 1, 0, 4'hF, 1);
    repeat (3) step(1, 1, 0, 4'hF, 1);

    // Fixed select on a non-valid channel, then it becomes valid.
    step(1, 0, 2, 4'b0101, 1);
    step(1, 0, 2, 4'b0101, 1);
    chd[2] = 32'h1234;
    step(1, 0, 2, 4'b0111, 1);
    step(1, 0, 2, 4'b0000, 1);

    // Back-pressure holding DEAD while ch1 waits.
    step(1, 0, 0, 4'b0000, 1);
    chd[0] = 32'hDEAD;
    chd[1] = 32'hBEEF;
    step(1, 0, 0, 4'b0001, 2);
    repeat (3) step(1, 0, 1, 4'b0010, 2);
    step(1, 0, 1, 4'b0010, 1);
    step(1, 0, 1, 4'b0000, 1);

    // Round-robin wrap between ch3 and ch0 from the reset pointer.
    step(0, 1, 0, 4'b1001, 1);
    repeat (4) step(1, 1, 0, 4'b1001, 1);

    // Randomized traffic with occasional resets and random back-pressure.
    repeat (400) begin
      for (int i = 0; i < N; i++) chd[i] = $urandom;
      step($urandom_range(0, 49) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, N - 1), 4'($urandom_range(0, 15)), $urandom_range(0, 2));
    end

    // Drain whatever is left.
    repeat (4) step(1, 1, 0, 4'b0000, 1);
    chk("sb_empty_at_end", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_arb_rr.md
# mux_arb_rr

Parametrised registered N-to-1 datapath multiplexer with valid/ready handshakes and two selection modes:
- fixed select, the direct successor of the 2:1 32-bit operand mux;
- round-robin arbitration between requesting channels.

It sits between multiple operand/result producers and a single consumer in the calculator datapath. It replaces ad-hoc combinational muxing with one registered, back-pressure-aware stage.

## Interface
Parameters:
- `WIDTH`, default 32: data width per channel.
- `NUM_CH`, default 4: number of input channels, ≥2.
- `CH_W`, default `$clog2(NUM_CH)`: channel index width. Derived; do not override.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `mode` in 1: selection mode. 0 = fixed select via `sel`; 1 = round-robin.
- `sel` in CH_W: channel select, used only when `mode`=0.
- `in_data` in NUM_CH*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid` in NUM_CH: per-channel data-valid.
- `in_ready` out NUM_CH: per-channel accept. High for at most one channel per cycle.
- `out_data` out WIDTH: registered selected data.
- `out_ch` out CH_W: index of the channel that supplied `out_data`.
- `out_valid` out 1: output register holds data.
- `out_ready` in 1: consumer accepts output.

## Operation
- `load` = !out_valid | out_ready. The output register can take new data this cycle.
- Grant vector is combinational from `in_valid`, `mode`, `sel` and the internal pointer `last`.
  - `mode`=0: grant channel `sel` iff `in_valid[sel]`. `sel` ≥ NUM_CH means no grant.
  - `mode`=1: grant the first channel with `in_valid` set, searching `last+1`, `last+2`, … with wrap modulo NUM_CH. Channel `last` itself has lowest priority.
- `in_ready[i]` = grant[i] & load. An input transfer occurs when `in_valid[i]` & `in_ready[i]`.
- On an input transfer of channel g:
  - `out_data` <= channel g data;
  - `out_ch` <= g;
  - `out_valid` <= 1;
  - `last` <= g. This applies in both modes.
- Output transfer without an input transfer (out_valid & out_ready, no grant): `out_valid` <= 0. `out_data` and `out_ch` hold their values.
- Simultaneous output drain and input transfer: the register is replaced with the new data and `out_valid` stays 1. This gives zero-bubble throughput of 1 word/cycle.
- out_valid=1 with out_ready=0:
  - all `in_ready` are 0;
  - the register and `last` hold.
- `mode` or `sel` changes take effect on the arbitration of the same cycle. Data already in the output register is unaffected.
- Data passes through unmodified. No width conversion or arithmetic.

## Timing
- Reset (rst_n=0 at a rising edge), which overrides all other activity in that cycle:
  - `out_valid`=0, `out_data`=0, `out_ch`=0;
  - `last`=NUM_CH-1, so channel 0 has top round-robin priority after reset;
  - `in_ready` is forced to 0 while rst_n=0.
- Reset mid-transfer: pending output data is discarded, no transfer is counted, and the state returns to reset values.
- Latency: input accepted at edge N appears on `out_data`/`out_valid` immediately after edge N. The consumer can take it at edge N+1.
- Throughput: 1 transfer/cycle while the consumer holds out_ready=1.
- `in_ready` is combinational from `in_valid`, `out_ready`, `mode` and `sel`.
- `out_*` are pure register outputs with no combinational path from inputs.
- Round-robin fairness: with all NUM_CH channels requesting continuously, each channel is granted exactly once every NUM_CH cycles.

## Test plan
Bench settings: WIDTH=32, NUM_CH=4.

1. Reset with all in_valid=4'b1111 and out_ready=1 -> `out_valid`=0 and `out_data`=0 after reset. The first grant after rst_n rises goes to ch0; `out_ch`=0 one cycle later.
2. mode=1, all four valid, out_ready=1, ch i data=32'hA0+i -> `out_data` sequence A0,A1,A2,A3,A0,… on consecutive cycles with no bubbles.
3. mode=0, sel=2, in_valid=4'b0101 -> ch2 is not valid, so all `in_ready`=0 and `out_valid` stays 0. Setting in_valid[2]=1 with data 32'h1234 -> out_data=32'h1234, out_ch=2 next cycle.
4. Back-pressure: the register holds 32'hDEAD, out_valid=1, out_ready=0 for 3 cycles while ch1 is valid -> in_ready=0 and out_data stays DEAD. When out_ready=1, that cycle drains DEAD and loads ch1 data; out_valid stays 1.
5. Round-robin wrap: last=3, in_valid=4'b1001 -> ch0 granted, then ch3, then ch0.
6. Reset mid-stream during test 2 -> out_valid=0 next cycle, and the first grant after reset goes to ch0 regardless of the pre-reset `last`.
